multicycle_control_unit: RTL and testbench
==========================================

# multicycle_control_unit

Control FSM and program counter for the simplified multicycle 16-bit RISC processor. Fetches instructions from memory, decodes the 5-bit opcode, and sequences the register-file/ALU datapath through fetch, decode, execute, memory and writeback. Drives the datapath select and enable lines, and consumes the ALU flags (C/Z/N) into a processor status word (PSW). Sits between instruction/data memory and the RF+ALU datapath.

## Interface
- No parameters. Widths are fixed: data/address 16, opcode 5, immediate 5/8/11.
- clk  in  1  system clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-low reset
- mem_rdata  in  16  memory read data; captured into IR during FETCH
- mem_ready  in  1  memory completion strobe for the current mem_req
- C, Z, N  in  1 each  ALU flags from the datapath, valid in EXECUTE
- mem_req  out  1  memory access request; held until mem_ready
- mem_we  out  1  write request; valid with mem_req
- mem_addr_sel  out  1  0: address = PC; 1: address = ALU Sum
- PC  out  16  program counter
- Ins  out  11  IR[10:0] to the datapath
- WBRF, WBresource, RBresource, OprandB, LI, ALUop, Flag  out  1 each  datapath controls
- WBsel_LI  out  1  writeback source outside the datapath: 0 = Sum, 1 = LI_EXE
- PSW_C  out  1  latched carry
- PSW_Z, PSW_N  out  1 each  latched flags
- halted  out  1  HALT executed

## Operation
- Opcode = IR[15:11]. Fields: Rd = IR[10:8], Rm = IR[7:5], Rn = IR[4:2], imm5 = IR[4:0], imm8 = IR[7:0], imm11 = IR[10:0].
- States: FETCH, DECODE, EXEC, MEM, WB, HALT.
- Instruction set and controls:
  - ADD 00000 / SUB 00001: OprandB = 0; ALUop = 0/1.
  - ADDI 00010 / SUBI 00011: OprandB = 1.
  - ADC 00100 / SBC 00101: Flag = 1.
  - LLI 00110: LI = 0; WBsel_LI = 1.
  - LHI 00111: LI = 1; RBresource = 1; WBsel_LI = 1.
  - LD 01000: Rd ← mem[Rm+imm5]; WBresource = 1.
  - ST 01001: mem[Rm+imm5] ← Rd; RBresource = 1.
  - B 01010, BZ 01011, BNZ 01100, BC 01101: PC ← PC + sext(imm11) when the condition on the PSW holds.
  - HALT 11111.
  - Any other opcode: treated as NOP.
- State transitions:
  - FETCH: mem_req = 1, mem_addr_sel = 0. On mem_ready: IR ← mem_rdata, PC ← PC+1, go to DECODE.
  - DECODE: branches, NOP and HALT complete here. Branches go to FETCH; HALT goes to HALT; all others go to EXEC.
  - EXEC: arithmetic ops latch the PSW from C/Z/N. LLI/LHI do not touch the PSW; LD/ST do not update flags. LD/ST go to MEM; all others go to WB.
  - MEM: mem_req = 1, mem_addr_sel = 1, mem_we = ST. Waits for mem_ready. LD then goes to WB; ST goes to FETCH.
  - WB: WBRF = 1 for one cycle, then go to FETCH.
  - HALT: terminal; halted = 1. Only Reset exits.
- Branch offset arithmetic wraps modulo 2^16 and is relative to the incremented PC.

## Timing
- All outputs are registered and reflect the state being entered. Reset values: every output 0, PC = 0, IR = 0, PSW = 0, state = FETCH.
- mem_req first rises on the first rising edge after Reset deasserts.
- Cycle counts with zero-wait memory (mem_ready in the same cycle as mem_req):
  - ALU/LI ops: 4 cycles.
  - LD: 5 cycles.
  - ST: 4 cycles.
  - Branch, NOP: 2 cycles.
- Each memory wait cycle adds one cycle. Outputs are held stable while waiting.
- mem_ready while mem_req = 0 is ignored.
- Datapath controls are stable from the entry of DECODE through WB, covering the datapath's falling-edge ID/EXE capture.
- The PSW updates on the rising edge that leaves EXEC. A branch in the next instruction sees the new flags.
- Reset asserted mid-operation: immediate return to reset values. A pending mem_req drops asynchronously.

## Structure
- Shared package mcrisc_pkg holds the opcode constants, the state encoding and the field bit positions. The datapath and the assembler test tables use the same package.
- One sub-module: mcrisc_decoder, a combinational map from opcode to a control bundle plus class bits (is_alu, is_mem, is_branch, writes_psw).
- FSM, PC and PSW stay in the top module.

## Test plan
- Reset release with zero-wait memory: first fetch at PC = 0x0000. ADDI R1,R0,5 → WBRF pulses in cycle 4, OprandB = 1, PC = 0x0001.
- SUB producing zero (R1 = R2 = 5) → PSW_Z = 1, PSW_N = 0. A following BZ with imm11 = 0x7FE lands at PC = old PC+1−2.
- LD with 3 wait cycles on each access → 11 cycles total, WBresource = 1 during WB, mem_addr_sel = 1 only in MEM.
- ST → mem_we = 1 only in MEM. No WBRF pulse. Returns to FETCH after mem_ready.
- LHI after LLI → RBresource = 1, LI = 1, WBsel_LI = 1. PSW unchanged from its previous value.
- HALT followed by Reset asserted mid-way through a FETCH wait → halted = 1 and stays. Reset clears all outputs asynchronously; after release PC = 0 and fetch restarts.

Source files
------------

// File: rtl/mcrisc_pkg.sv
// Shared definitions for the multicycle 16-bit RISC: opcodes, FSM states,
// instruction field positions and the decoded control bundle.
package mcrisc_pkg;

    localparam int DATA_W = 16;
    localparam int OPC_W  = 5;

    // Instruction field bit positions
    localparam int OPC_MSB   = 15;
    localparam int OPC_LSB   = 11;
    localparam int RD_MSB    = 10;
    localparam int RD_LSB    = 8;
    localparam int RM_MSB    = 7;
    localparam int RM_LSB    = 5;
    localparam int RN_MSB    = 4;
    localparam int RN_LSB    = 2;
    localparam int IMM5_MSB  = 4;
    localparam int IMM8_MSB  = 7;
    localparam int IMM11_MSB = 10;

    // Opcodes
    localparam logic [OPC_W-1:0] OP_ADD  = 5'b00000;
    localparam logic [OPC_W-1:0] OP_SUB  = 5'b00001;
    localparam logic [OPC_W-1:0] OP_ADDI = 5'b00010;
    localparam logic [OPC_W-1:0] OP_SUBI = 5'b00011;
    localparam logic [OPC_W-1:0] OP_ADC  = 5'b00100;
    localparam logic [OPC_W-1:0] OP_SBC  = 5'b00101;
    localparam logic [OPC_W-1:0] OP_LLI  = 5'b00110;
    localparam logic [OPC_W-1:0] OP_LHI  = 5'b00111;
    localparam logic [OPC_W-1:0] OP_LD   = 5'b01000;
    localparam logic [OPC_W-1:0] OP_ST   = 5'b01001;
    localparam logic [OPC_W-1:0] OP_B    = 5'b01010;
    localparam logic [OPC_W-1:0] OP_BZ   = 5'b01011;
    localparam logic [OPC_W-1:0] OP_BNZ  = 5'b01100;
    localparam logic [OPC_W-1:0] OP_BC   = 5'b01101;
    localparam logic [OPC_W-1:0] OP_HALT = 5'b11111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Datapath controls plus the class bits the sequencer needs
    typedef struct packed {
        logic oprandB;
        logic li;
        logic aluOp;
        logic flag;
        logic wbResource;
        logic rbResource;
        logic wbSelLi;
        logic isAlu;
        logic isMem;
        logic isStore;
        logic isBranch;
        logic isHalt;
        logic writesPsw;
    } ctrl_t;

    // Sign-extend an 11-bit branch offset to the 16-bit address width
    function automatic logic [DATA_W-1:0] sext11(input logic [IMM11_MSB:0] imm);
        return {{(DATA_W-IMM11_MSB-1){imm[IMM11_MSB]}}, imm};
    endfunction

endpackage

// File: rtl/mcrisc_decoder.sv
// Combinational opcode decoder: maps the 5-bit opcode to datapath controls
// and instruction class bits. Unlisted opcodes decode to all-zero (NOP).
module mcrisc_decoder
    import mcrisc_pkg::*;
(
    input  logic [OPC_W-1:0] i_opcode,
    output ctrl_t            o_ctrl
);

    // Opcode to control bundle; LD/ST select the immediate so Sum = Rm+imm5
    always_comb begin
        o_ctrl = '0;
        case (i_opcode)
            OP_ADD: begin
                o_ctrl.isAlu     = 1'b1;
                o_ctrl.writesPsw = 1'b1;
            end
            OP_SUB: begin
                o_ctrl.aluOp     = 1'b1;
                o_ctrl.isAlu     = 1'b1;
                o_ctrl.writesPsw = 1'b1;
            end
            OP_ADDI: begin
                o_ctrl.oprandB   = 1'b1;
                o_ctrl.isAlu     = 1'b1;
                o_ctrl.writesPsw = 1'b1;
            end
            OP_SUBI: begin
                o_ctrl.oprandB   = 1'b1;
                o_ctrl.aluOp     = 1'b1;
                o_ctrl.isAlu     = 1'b1;
                o_ctrl.writesPsw = 1'b1;
            end
            OP_ADC: begin
                o_ctrl.flag      = 1'b1;
                o_ctrl.isAlu     = 1'b1;
                o_ctrl.writesPsw = 1'b1;
            end
            OP_SBC: begin
                o_ctrl.flag      = 1'b1;
                o_ctrl.aluOp     = 1'b1;
                o_ctrl.isAlu     = 1'b1;
                o_ctrl.writesPsw = 1'b1;
            end
            OP_LLI: begin
                o_ctrl.wbSelLi = 1'b1;
                o_ctrl.isAlu   = 1'b1;
            end
            OP_LHI: begin
                o_ctrl.li         = 1'b1;
                o_ctrl.rbResource = 1'b1;
                o_ctrl.wbSelLi    = 1'b1;
                o_ctrl.isAlu      = 1'b1;
            end
            OP_LD: begin
                o_ctrl.oprandB    = 1'b1;
                o_ctrl.wbResource = 1'b1;
                o_ctrl.isMem      = 1'b1;
            end
            OP_ST: begin
                o_ctrl.oprandB    = 1'b1;
                o_ctrl.rbResource = 1'b1;
                o_ctrl.isMem      = 1'b1;
                o_ctrl.isStore    = 1'b1;
            end
            OP_B, OP_BZ, OP_BNZ, OP_BC: begin
                o_ctrl.isBranch = 1'b1;
            end
            OP_HALT: begin
                o_ctrl.isHalt = 1'b1;
            end
            default: begin
                o_ctrl = '0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Control FSM, program counter and PSW for the multicycle 16-bit RISC.
// Every output is registered and reflects the state being entered.
module multicycle_control_unit
    import mcrisc_pkg::*;
(
    input  logic              clk,
    input  logic              Reset,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    input  logic              C,
    input  logic              Z,
    input  logic              N,
    output logic              mem_req,
    output logic              mem_we,
    output logic              mem_addr_sel,
    output logic [DATA_W-1:0] PC,
    output logic [10:0]       Ins,
    output logic              WBRF,
    output logic              WBresource,
    output logic              RBresource,
    output logic              OprandB,
    output logic              LI,
    output logic              ALUop,
    output logic              Flag,
    output logic              WBsel_LI,
    output logic              PSW_C,
    output logic              PSW_Z,
    output logic              PSW_N,
    output logic              halted
);

    state_t            r_state;
    logic              r_memReq;
    logic              r_memWe;
    logic              r_addrSel;
    logic              r_wbrf;
    logic              r_halted;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] r_ir;
    ctrl_t             r_ctrl;
    logic              r_pswC;
    logic              r_pswZ;
    logic              r_pswN;

    state_t            w_nextState;
    ctrl_t             w_ctrlIn;
    logic [OPC_W-1:0]  w_opcode;
    logic              w_memDone;
    logic              w_loadIr;
    logic              w_takeBranch;
    logic              w_latchPsw;
    logic              w_branchCond;
    logic              w_nextMemReq;
    logic              w_nextMemWe;
    logic              w_nextAddrSel;
    logic              w_nextWbrf;
    logic              w_nextHalted;
    logic [DATA_W-1:0] w_branchTarget;

    // Decode the word on the memory bus so controls are ready on DECODE entry
    mcrisc_decoder u_decoder (
        .i_opcode (mem_rdata[OPC_MSB:OPC_LSB]),
        .o_ctrl   (w_ctrlIn)
    );

    assign w_opcode       = r_ir[OPC_MSB:OPC_LSB];
    assign w_memDone      = r_memReq && mem_ready;
    assign w_branchTarget = r_pc + sext11(r_ir[IMM11_MSB:0]);

    // Branch condition evaluated against the latched PSW
    always_comb begin
        w_branchCond = 1'b0;
        case (w_opcode)
            OP_B:    w_branchCond = 1'b1;
            OP_BZ:   w_branchCond = r_pswZ;
            OP_BNZ:  w_branchCond = !r_pswZ;
            OP_BC:   w_branchCond = r_pswC;
            default: w_branchCond = 1'b0;
        endcase
    end

    // Next-state logic and the registered outputs for the state being entered
    always_comb begin
        w_nextState  = r_state;
        w_loadIr     = 1'b0;
        w_takeBranch = 1'b0;
        w_latchPsw   = 1'b0;
        case (r_state)
            ST_FETCH: begin
                if (w_memDone) begin
                    w_loadIr    = 1'b1;
                    w_nextState = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (r_ctrl.isBranch) begin
                    w_takeBranch = w_branchCond;
                    w_nextState  = ST_FETCH;
                end else if (r_ctrl.isHalt) begin
                    w_nextState = ST_HALT;
                end else if (r_ctrl.isAlu || r_ctrl.isMem) begin
                    w_nextState = ST_EXEC;
                end else begin
                    w_nextState = ST_FETCH;
                end
            end
            ST_EXEC: begin
                w_latchPsw  = r_ctrl.writesPsw;
                w_nextState = r_ctrl.isMem ? ST_MEM : ST_WB;
            end
            ST_MEM: begin
                if (w_memDone) begin
                    w_nextState = r_ctrl.isStore ? ST_FETCH : ST_WB;
                end
            end
            ST_WB: begin
                w_nextState = ST_FETCH;
            end
            ST_HALT: begin
                w_nextState = ST_HALT;
            end
            default: begin
                w_nextState = ST_FETCH;
            end
        endcase

        w_nextMemReq  = (w_nextState == ST_FETCH) || (w_nextState == ST_MEM);
        w_nextAddrSel = (w_nextState == ST_MEM);
        w_nextMemWe   = (w_nextState == ST_MEM) && r_ctrl.isStore;
        w_nextWbrf    = (w_nextState == ST_WB);
        w_nextHalted  = (w_nextState == ST_HALT);
    end

    // State register
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Registered outputs, IR/controls capture, PC and PSW updates
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            r_memReq  <= 1'b0;
            r_memWe   <= 1'b0;
            r_addrSel <= 1'b0;
            r_wbrf    <= 1'b0;
            r_halted  <= 1'b0;
            r_pc      <= '0;
            r_ir      <= '0;
            r_ctrl    <= '0;
            r_pswC    <= 1'b0;
            r_pswZ    <= 1'b0;
            r_pswN    <= 1'b0;
        end else begin
            r_memReq  <= w_nextMemReq;
            r_memWe   <= w_nextMemWe;
            r_addrSel <= w_nextAddrSel;
            r_wbrf    <= w_nextWbrf;
            r_halted  <= w_nextHalted;
            if (w_loadIr) begin
                r_ir   <= mem_rdata;
                r_ctrl <= w_ctrlIn;
                r_pc   <= r_pc + 16'd1;
            end else if (w_takeBranch) begin
                r_pc <= w_branchTarget;
            end
            if (w_latchPsw) begin
                r_pswC <= C;
                r_pswZ <= Z;
                r_pswN <= N;
            end
        end
    end

    assign mem_req      = r_memReq;
    assign mem_we       = r_memWe;
    assign mem_addr_sel = r_addrSel;
    assign PC           = r_pc;
    assign Ins          = r_ir[IMM11_MSB:0];
    assign WBRF         = r_wbrf;
    assign WBresource   = r_ctrl.wbResource;
    assign RBresource   = r_ctrl.rbResource;
    assign OprandB      = r_ctrl.oprandB;
    assign LI           = r_ctrl.li;
    assign ALUop        = r_ctrl.aluOp;
    assign Flag         = r_ctrl.flag;
    assign WBsel_LI     = r_ctrl.wbSelLi;
    assign PSW_C        = r_pswC;
    assign PSW_Z        = r_pswZ;
    assign PSW_N        = r_pswN;
    assign halted       = r_halted;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: a hand-sequenced program of
// ADDI, SUB, BZ, LLI, LHI, LD (with waits), ST, NOP, BNZ and HALT, plus resets.
module tb_multicycle_control_unit;

    logic        clk;
    logic        Reset;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic        C, Z, N;
    logic        mem_req, mem_we, mem_addr_sel;
    logic [15:0] PC;
    logic [10:0] Ins;
    logic        WBRF, WBresource, RBresource, OprandB, LI, ALUop, Flag, WBsel_LI;
    logic        PSW_C, PSW_Z, PSW_N, halted;

    int checks;
    int failures;

    multicycle_control_unit dut (
        .clk          (clk),
        .Reset        (Reset),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .C            (C),
        .Z            (Z),
        .N            (N),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .PC           (PC),
        .Ins          (Ins),
        .WBRF         (WBRF),
        .WBresource   (WBresource),
        .RBresource   (RBresource),
        .OprandB      (OprandB),
        .LI           (LI),
        .ALUop        (ALUop),
        .Flag         (Flag),
        .WBsel_LI     (WBsel_LI),
        .PSW_C        (PSW_C),
        .PSW_Z        (PSW_Z),
        .PSW_N        (PSW_N),
        .halted       (halted)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic applyStimulus(input logic [15:0] rdata, input logic ready,
                                 input logic c, input logic z, input logic n);
        mem_rdata = rdata;
        mem_ready = ready;
        C = c;
        Z = z;
        N = n;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Directed program sequence
    initial begin
        checks    = 0;
        failures  = 0;
        Reset     = 1'b0;
        mem_rdata = 16'h0000;
        mem_ready = 1'b1;
        C = 1'b0; Z = 1'b0; N = 1'b0;
        #3;
        checkOutput("rst_mem_req", {15'd0, mem_req}, 16'd0);
        checkOutput("rst_pc", PC, 16'h0000);
        checkOutput("rst_halted", {15'd0, halted}, 16'd0);
        checkOutput("rst_wbrf", {15'd0, WBRF}, 16'd0);
        checkOutput("rst_ins", {5'd0, Ins}, 16'd0);
        @(posedge clk);
        #1;
        Reset = 1'b1;

        // ADDI R1,R0,5 = 0x1105; mem_ready high before mem_req is ignored
        applyStimulus(16'h1105, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("c1_mem_req", {15'd0, mem_req}, 16'd1);
        checkOutput("c1_addr_sel", {15'd0, mem_addr_sel}, 16'd0);
        checkOutput("c1_pc", PC, 16'h0000);
        applyStimulus(16'h1105, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("addi_dec_mem_req", {15'd0, mem_req}, 16'd0);
        checkOutput("addi_dec_pc", PC, 16'h0001);
        checkOutput("addi_oprandB", {15'd0, OprandB}, 16'd1);
        checkOutput("addi_aluop", {15'd0, ALUop}, 16'd0);
        checkOutput("addi_ins", {5'd0, Ins}, 16'h0105);
        applyStimulus(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("addi_exec_wbrf", {15'd0, WBRF}, 16'd0);
        applyStimulus(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("addi_wb_wbrf", {15'd0, WBRF}, 16'd1);
        checkOutput("addi_wb_oprandB", {15'd0, OprandB}, 16'd1);

        // SUB R3,R1,R2 = 0x0B28 producing zero
        applyStimulus(16'h0B28, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("sub_fetch_req", {15'd0, mem_req}, 16'd1);
        checkOutput("sub_fetch_wbrf", {15'd0, WBRF}, 16'd0);
        applyStimulus(16'h0B28, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("sub_dec_pc", PC, 16'h0002);
        checkOutput("sub_aluop", {15'd0, ALUop}, 16'd1);
        checkOutput("sub_oprandB", {15'd0, OprandB}, 16'd0);
        applyStimulus(16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("sub_exec_psw_z_old", {15'd0, PSW_Z}, 16'd0);
        applyStimulus(16'h0000, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("sub_psw_z", {15'd0, PSW_Z}, 16'd1);
        checkOutput("sub_psw_n", {15'd0, PSW_N}, 16'd0);
        checkOutput("sub_psw_c", {15'd0, PSW_C}, 16'd1);
        checkOutput("sub_wb_wbrf", {15'd0, WBRF}, 16'd1);

        // BZ imm11=0x7FE = 0x5FFE at address 2 -> PC = 3 - 2 = 1
        applyStimulus(16'h5FFE, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'h5FFE, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("bz_dec_pc", PC, 16'h0003);
        checkOutput("bz_ins", {5'd0, Ins}, 16'h07FE);
        applyStimulus(16'h3434, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("bz_target_pc", PC, 16'h0001);
        checkOutput("bz_fetch_req", {15'd0, mem_req}, 16'd1);

        // LLI R4,#0x34 = 0x3434; flags on the inputs must not reach the PSW
        applyStimulus(16'h3434, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("lli_pc", PC, 16'h0002);
        checkOutput("lli_li", {15'd0, LI}, 16'd0);
        checkOutput("lli_wbsel", {15'd0, WBsel_LI}, 16'd1);
        checkOutput("lli_rbres", {15'd0, RBresource}, 16'd0);
        applyStimulus(16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(16'h0000, 1'b1, 1'b0, 1'b0, 1'b1);
        checkOutput("lli_wbrf", {15'd0, WBRF}, 16'd1);
        checkOutput("lli_psw_z_kept", {15'd0, PSW_Z}, 16'd1);
        checkOutput("lli_psw_n_kept", {15'd0, PSW_N}, 16'd0);

        // LHI R4,#0x12 = 0x3C12
        applyStimulus(16'h3C12, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'h3C12, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("lhi_pc", PC, 16'h0003);
        checkOutput("lhi_li", {15'd0, LI}, 16'd1);
        checkOutput("lhi_rbres", {15'd0, RBresource}, 16'd1);
        checkOutput("lhi_wbsel", {15'd0, WBsel_LI}, 16'd1);
        applyStimulus(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("lhi_wbrf", {15'd0, WBRF}, 16'd1);
        checkOutput("lhi_psw_z_kept", {15'd0, PSW_Z}, 16'd1);
        checkOutput("lhi_psw_c_kept", {15'd0, PSW_C}, 16'd1);

        // LD R5,[R1,#2] = 0x4522 with three wait cycles on each access
        applyStimulus(16'h4522, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ld_fetch_req", {15'd0, mem_req}, 16'd1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'h4522, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("ld_fwait_req", {15'd0, mem_req}, 16'd1);
            checkOutput("ld_fwait_pc", PC, 16'h0003);
            checkOutput("ld_fwait_sel", {15'd0, mem_addr_sel}, 16'd0);
        end
        applyStimulus(16'h4522, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("ld_dec_pc", PC, 16'h0004);
        checkOutput("ld_wbres", {15'd0, WBresource}, 16'd1);
        checkOutput("ld_dec_req", {15'd0, mem_req}, 16'd0);
        applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ld_exec_sel", {15'd0, mem_addr_sel}, 16'd0);
        applyStimulus(16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("ld_mem_req", {15'd0, mem_req}, 16'd1);
        checkOutput("ld_mem_sel", {15'd0, mem_addr_sel}, 16'd1);
        checkOutput("ld_mem_we", {15'd0, mem_we}, 16'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'hBEEF, 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("ld_mwait_sel", {15'd0, mem_addr_sel}, 16'd1);
            checkOutput("ld_mwait_wbrf", {15'd0, WBRF}, 16'd0);
        end
        applyStimulus(16'hBEEF, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("ld_wb_wbrf", {15'd0, WBRF}, 16'd1);
        checkOutput("ld_wb_wbres", {15'd0, WBresource}, 16'd1);
        checkOutput("ld_wb_sel", {15'd0, mem_addr_sel}, 16'd0);
        checkOutput("ld_wb_req", {15'd0, mem_req}, 16'd0);
        checkOutput("ld_wb_ins", {5'd0, Ins}, 16'h0522);

        // ST R6,[R1,#3] = 0x4E23
        applyStimulus(16'h4E23, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("st_fetch_wbrf", {15'd0, WBRF}, 16'd0);
        applyStimulus(16'h4E23, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("st_dec_pc", PC, 16'h0005);
        checkOutput("st_rbres", {15'd0, RBresource}, 16'd1);
        checkOutput("st_dec_we", {15'd0, mem_we}, 16'd0);
        applyStimulus(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("st_exec_we", {15'd0, mem_we}, 16'd0);
        applyStimulus(16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("st_mem_we", {15'd0, mem_we}, 16'd1);
        checkOutput("st_mem_sel", {15'd0, mem_addr_sel}, 16'd1);
        checkOutput("st_mem_wbrf", {15'd0, WBRF}, 16'd0);
        applyStimulus(16'h8000, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("st_back_we", {15'd0, mem_we}, 16'd0);
        checkOutput("st_back_wbrf", {15'd0, WBRF}, 16'd0);
        checkOutput("st_back_req", {15'd0, mem_req}, 16'd1);
        checkOutput("st_back_sel", {15'd0, mem_addr_sel}, 16'd0);

        // NOP (opcode 10000) takes two cycles
        applyStimulus(16'h8000, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("nop_dec_pc", PC, 16'h0006);
        applyStimulus(16'h6005, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("nop_fetch_req", {15'd0, mem_req}, 16'd1);

        // BNZ +5 = 0x6005 with Z=1 is not taken
        applyStimulus(16'h6005, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("bnz_dec_pc", PC, 16'h0007);
        applyStimulus(16'hF800, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("bnz_nt_pc", PC, 16'h0007);

        // HALT = 0xF800
        applyStimulus(16'hF800, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("halt_dec_pc", PC, 16'h0008);
        applyStimulus(16'h1105, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("halt_flag", {15'd0, halted}, 16'd1);
        checkOutput("halt_req", {15'd0, mem_req}, 16'd0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(16'h1105, 1'b1, 1'b0, 1'b0, 1'b0);
            checkOutput("halt_stay", {15'd0, halted}, 16'd1);
            checkOutput("halt_pc", PC, 16'h0008);
        end

        // Asynchronous reset out of HALT
        Reset = 1'b0;
        #1;
        checkOutput("rst2_halted", {15'd0, halted}, 16'd0);
        checkOutput("rst2_pc", PC, 16'h0000);
        checkOutput("rst2_psw_z", {15'd0, PSW_Z}, 16'd0);
        checkOutput("rst2_psw_c", {15'd0, PSW_C}, 16'd0);
        checkOutput("rst2_ins", {5'd0, Ins}, 16'd0);
        checkOutput("rst2_rbres", {15'd0, RBresource}, 16'd0);
        @(posedge clk);
        #1;
        Reset = 1'b1;

        // Fetch restarts, then reset lands in the middle of a wait
        applyStimulus(16'h1105, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst2_fetch_req", {15'd0, mem_req}, 16'd1);
        checkOutput("rst2_fetch_pc", PC, 16'h0000);
        applyStimulus(16'h1105, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("rst2_wait_req", {15'd0, mem_req}, 16'd1);
        #2;
        Reset = 1'b0;
        #1;
        checkOutput("rst3_req_drop", {15'd0, mem_req}, 16'd0);
        @(posedge clk);
        #1;
        Reset = 1'b1;
        applyStimulus(16'h1105, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("rst3_fetch_req", {15'd0, mem_req}, 16'd1);
        checkOutput("rst3_fetch_pc", PC, 16'h0000);
        applyStimulus(16'h1105, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("rst3_dec_pc", PC, 16'h0001);
        checkOutput("rst3_oprandB", {15'd0, OprandB}, 16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
